// File: rtl/calc3_port_sequencer.sv
// calc3_port_sequencer
// Sequences one CALC3 request port. Host commands arrive over valid/ready.
// Each command gets the lowest free 2-bit tag and is driven to calc3_top as
// a one-cycle request. Up to four tags are tracked in flight. Responses are
// matched by tag, lost requests are turned into synthetic timeout responses,
// and everything returns to the host in arrival order through a FWFT FIFO.
module calc3_port_sequencer #(
   parameter int unsigned RSP_DEPTH = 4,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [3:0]  cmd_d1,
   input  logic [3:0]  cmd_d2,
   input  logic [3:0]  cmd_r1,
   input  logic [31:0] cmd_data,
   output logic [3:0]  req_cmd,
   output logic [3:0]  req_d1,
   output logic [3:0]  req_d2,
   output logic [3:0]  req_r1,
   output logic [31:0] req_data,
   output logic [1:0]  req_tag,
   input  logic [1:0]  out_resp,
   input  logic [31:0] out_data,
   input  logic [1:0]  out_tag,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [1:0]  rsp_code,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_tag,
   output logic [3:0]  rsp_op,
   output logic [2:0]  inflight,
   output logic        err_unexp
);

   // Timer width is $clog2(TIMEOUT+1); with TIMEOUT=0 the timer shrinks to one unused bit.
   localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
   localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

   localparam logic [1:0] CODE_TIMEOUT = 2'd3;

   typedef struct packed {
      logic [1:0]  code;
      logic [31:0] data;
      logic [1:0]  tag;
      logic [3:0]  op;
   } rsp_entry_t;

   // Tag table and in-flight timers
   logic [3:0]    busy;
   logic [3:0]    busy_next;
   logic [3:0]    op_tab [4];
   logic [TW-1:0] timer  [4];

   // Response FIFO
   rsp_entry_t    mem [RSP_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] fifo_count;

   // Per-cycle decisions
   logic          have_free;
   logic [1:0]    free_tag;
   logic [31:0]   occupancy;
   logic          accept;
   logic          issue;
   logic          real_hit;
   logic          unexp_hit;
   logic          to_fire;
   logic [1:0]    to_tag;
   logic          push;
   logic          pop;
   rsp_entry_t    push_entry;
   rsp_entry_t    head;
   logic [2:0]    inflight_next;

   // Tag allocation, credit check, response/timeout arbitration and FIFO head.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch can be inferred;
      // combinational logic uses blocking '=', clocked state below uses '<='.
      have_free = 1'b0;
      free_tag  = 2'd0;
      // Scan high to low so the lowest free tag is the one that sticks.
      for (int i = 3; i >= 0; i--) begin
         if (!busy[i]) begin
            have_free = 1'b1;
            free_tag  = 2'(i);
         end
      end

      // Every busy tag will eventually need exactly one FIFO slot.
      occupancy = 32'(inflight) + 32'(fifo_count);
      cmd_ready = !reset && have_free && (occupancy < RSP_DEPTH);
      accept    = cmd_valid && cmd_ready;
      issue     = accept && (cmd_op != 4'd0);

      real_hit  = (out_resp != 2'd0) &&  busy[out_tag];
      unexp_hit = (out_resp != 2'd0) && !busy[out_tag];

      // A real response owns the push slot; expired tags wait, lowest first.
      to_fire = 1'b0;
      to_tag  = 2'd0;
      if (TIMEOUT > 0 && !real_hit) begin
         for (int i = 3; i >= 0; i--) begin
            if (busy[i] && timer[i] == TW'(TIMEOUT)) begin
               to_fire = 1'b1;
               to_tag  = 2'(i);
            end
         end
      end

      push = real_hit || to_fire;
      if (real_hit) begin
         push_entry.code = out_resp;
         push_entry.data = out_data;
         push_entry.tag  = out_tag;
         push_entry.op   = op_tab[out_tag];
      end else begin
         push_entry.code = CODE_TIMEOUT;
         push_entry.data = '0;
         push_entry.tag  = to_tag;
         push_entry.op   = op_tab[to_tag];
      end

      head      = mem[rd_ptr];
      rsp_valid = (fifo_count != '0);
      pop       = rsp_valid && rsp_ready;
      // The FIFO storage is not reset, so the head is masked until valid.
      rsp_code  = rsp_valid ? head.code : '0;
      rsp_data  = rsp_valid ? head.data : '0;
      rsp_tag   = rsp_valid ? head.tag  : '0;
      rsp_op    = rsp_valid ? head.op   : '0;

      // A tag freed this cycle is never the issue tag: allocation saw it busy.
      busy_next = busy;
      if (real_hit) busy_next[out_tag] = 1'b0;
      if (to_fire)  busy_next[to_tag]  = 1'b0;
      if (issue)    busy_next[free_tag] = 1'b1;

      inflight_next = 3'd0;
      for (int i = 0; i < 4; i++) begin
         inflight_next = inflight_next + {2'b00, busy_next[i]};
      end
   end

   // Control state: tag ownership, timers, request outputs, error pulse, FIFO pointers.
   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         busy       <= '0;
         inflight   <= '0;
         err_unexp  <= 1'b0;
         req_cmd    <= '0;
         req_d1     <= '0;
         req_d2     <= '0;
         req_r1     <= '0;
         req_data   <= '0;
         req_tag    <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
         for (int i = 0; i < 4; i++) begin
            timer[i] <= '0;
         end
      end else begin
         busy      <= busy_next;
         inflight  <= inflight_next;
         err_unexp <= unexp_hit;

         req_cmd  <= issue ? cmd_op   : '0;
         req_d1   <= issue ? cmd_d1   : '0;
         req_d2   <= issue ? cmd_d2   : '0;
         req_r1   <= issue ? cmd_r1   : '0;
         req_data <= issue ? cmd_data : '0;
         req_tag  <= issue ? free_tag : '0;

         for (int i = 0; i < 4; i++) begin
            if (issue && free_tag == 2'(i)) begin
               timer[i] <= '0;
            end else if (TIMEOUT > 0 && busy[i] && timer[i] != TW'(TIMEOUT)) begin
               timer[i] <= timer[i] + TW'(1);
            end
         end

         if (push) begin
            wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Payload storage: op per tag and FIFO entries.
   // NOTE: pure storage is left unreset; busy/count qualify every read of it.
   always_ff @(posedge c_clk) begin
      if (issue) op_tab[free_tag] <= cmd_op;
      if (push)  mem[wr_ptr]      <= push_entry;
   end

   // Credit accounting must make a push into a full FIFO unreachable.
   a_no_overflow : assert property (@(posedge c_clk) disable iff (reset)
      !(push && !pop && (fifo_count == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_calc3_port_sequencer.sv
// tb_calc3_port_sequencer
// Directed scenarios plus a randomized run against a transaction-level model
// (tag ownership flags, age counters and a queue of expected responses).
module tb_calc3_port_sequencer;

   localparam int DEPTH = 4;
   localparam int TMO   = 8;

   logic        c_clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = '0, cmd_d1 = '0, cmd_d2 = '0, cmd_r1 = '0;
   logic [31:0] cmd_data = '0;
   logic [3:0]  req_cmd, req_d1, req_d2, req_r1;
   logic [31:0] req_data;
   logic [1:0]  req_tag;
   logic [1:0]  out_resp = '0;
   logic [31:0] out_data = '0;
   logic [1:0]  out_tag = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_code;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_tag;
   logic [3:0]  rsp_op;
   logic [2:0]  inflight;
   logic        err_unexp;
   logic [95:0] all_out;

   int tests_run = 0;
   int tests_failed = 0;

   calc3_port_sequencer #(.RSP_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .c_clk(c_clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_d1(cmd_d1), .cmd_d2(cmd_d2), .cmd_r1(cmd_r1), .cmd_data(cmd_data),
      .req_cmd(req_cmd), .req_d1(req_d1), .req_d2(req_d2), .req_r1(req_r1),
      .req_data(req_data), .req_tag(req_tag),
      .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code),
      .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_op(rsp_op),
      .inflight(inflight), .err_unexp(err_unexp)
   );

   assign all_out = {cmd_ready, req_cmd, req_d1, req_d2, req_r1, req_data, req_tag,
                     rsp_valid, rsp_code, rsp_data, rsp_tag, rsp_op, inflight, err_unexp};

   always #5 c_clk = ~c_clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [1:0]  code;
      logic [31:0] data;
      logic [1:0]  tag;
      logic [3:0]  op;
   } exp_t;

   exp_t        m_q[$];
   bit          m_busy [4];
   int          m_age  [4];
   logic [3:0]  m_op   [4];
   logic [3:0]  m_req_cmd, m_req_d1, m_req_d2, m_req_r1;
   logic [31:0] m_req_data;
   logic [1:0]  m_req_tag;
   logic        m_err;

   function automatic void model_reset();
      m_q.delete();
      for (int i = 0; i < 4; i++) begin
         m_busy[i] = 1'b0;
         m_age[i]  = 0;
         m_op[i]   = '0;
      end
      m_req_cmd = '0; m_req_d1 = '0; m_req_d2 = '0; m_req_r1 = '0;
      m_req_data = '0; m_req_tag = '0; m_err = 1'b0;
   endfunction

   function automatic int m_nbusy();
      int n = 0;
      for (int i = 0; i < 4; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   function automatic int m_free_tag();
      for (int i = 0; i < 4; i++) if (!m_busy[i]) return i;
      return -1;
   endfunction

   function automatic logic m_ready();
      return !reset && (m_free_tag() >= 0) && (m_nbusy() + m_q.size() < DEPTH);
   endfunction

   // Advance the model by one clock using the inputs currently applied.
   function automatic void model_step();
      logic rdy;
      int   nt;
      bit   pushed;
      exp_t e;
      if (reset) begin
         model_reset();
         return;
      end
      rdy = m_ready();
      nt  = m_free_tag();
      if (m_q.size() > 0 && rsp_ready) void'(m_q.pop_front());
      m_err  = 1'b0;
      pushed = 1'b0;
      if (out_resp != 2'd0) begin
         if (m_busy[out_tag]) begin
            e.code = out_resp; e.data = out_data; e.tag = out_tag; e.op = m_op[out_tag];
            m_q.push_back(e);
            m_busy[out_tag] = 1'b0;
            pushed = 1'b1;
         end else begin
            m_err = 1'b1;
         end
      end
      if (!pushed && TMO > 0) begin
         for (int t = 0; t < 4; t++) begin
            if (m_busy[t] && m_age[t] >= TMO) begin
               e.code = 2'd3; e.data = '0; e.tag = 2'(t); e.op = m_op[t];
               m_q.push_back(e);
               m_busy[t] = 1'b0;
               break;
            end
         end
      end
      for (int t = 0; t < 4; t++) if (m_busy[t] && m_age[t] < TMO) m_age[t]++;
      if (cmd_valid && rdy && cmd_op != 4'd0) begin
         m_busy[nt] = 1'b1; m_age[nt] = 0; m_op[nt] = cmd_op;
         m_req_cmd = cmd_op; m_req_d1 = cmd_d1; m_req_d2 = cmd_d2; m_req_r1 = cmd_r1;
         m_req_data = cmd_data; m_req_tag = 2'(nt);
      end else begin
         m_req_cmd = '0; m_req_d1 = '0; m_req_d2 = '0; m_req_r1 = '0;
         m_req_data = '0; m_req_tag = '0;
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic cycle();
      model_step();
      @(posedge c_clk);
      #1;
   endtask

   task automatic set_cmd(input logic [3:0] op, input logic [3:0] d1, input logic [3:0] d2,
                          input logic [3:0] r1, input logic [31:0] data);
      cmd_valid = 1'b1; cmd_op = op; cmd_d1 = d1; cmd_d2 = d2; cmd_r1 = r1; cmd_data = data;
   endtask

   task automatic do_reset();
      cmd_valid = 1'b0; cmd_op = '0; out_resp = '0; rsp_ready = 1'b0;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      cycle();
      cycle();
      tests_run++;
      if (all_out !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h expected 0", all_out);
      end
      reset = 1'b0;
      #1;
      tests_run++;
      if (cmd_ready !== 1'b1 || inflight !== 3'd0 || rsp_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release: ready=%b inflight=%0d rsp_valid=%b expected 1/0/0",
                  cmd_ready, inflight, rsp_valid);
      end
   endtask

   task automatic test_single_issue();
      do_reset();
      set_cmd(4'd1, 4'd1, 4'd2, 4'd3, 32'd0);
      cycle();
      cmd_valid = 1'b0;
      tests_run++;
      if ({req_cmd, req_tag, req_d1, req_d2, req_r1, req_data, inflight} !==
          {4'd1, 2'd0, 4'd1, 4'd2, 4'd3, 32'd0, 3'd1}) begin
         tests_failed++;
         $display("FAIL single_req: got cmd=%0d tag=%0d d1=%0d d2=%0d r1=%0d inflight=%0d expected 1 0 1 2 3 1",
                  req_cmd, req_tag, req_d1, req_d2, req_r1, inflight);
      end
      cycle();
      tests_run++;
      if (req_cmd !== 4'd0) begin
         tests_failed++;
         $display("FAIL single_req_one_cycle: got req_cmd=%0d expected 0", req_cmd);
      end
      out_resp = 2'd1; out_tag = 2'd0; out_data = 32'd5;
      cycle();
      out_resp = 2'd0;
      tests_run++;
      if ({rsp_valid, rsp_code, rsp_data, rsp_tag, rsp_op, inflight} !==
          {1'b1, 2'd1, 32'd5, 2'd0, 4'd1, 3'd0}) begin
         tests_failed++;
         $display("FAIL single_rsp: got v=%b code=%0d data=%0d tag=%0d op=%0d inflight=%0d expected 1 1 5 0 1 0",
                  rsp_valid, rsp_code, rsp_data, rsp_tag, rsp_op, inflight);
      end
      rsp_ready = 1'b1;
      cycle();
      rsp_ready = 1'b0;
      tests_run++;
      if (rsp_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_pop: got rsp_valid=%b expected 0", rsp_valid);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_cmd(4'(i + 1), 4'(i), 4'(i + 4), 4'(i + 8), 32'($urandom));
         cycle();
         tests_run++;
         if (req_tag !== 2'(i) || req_cmd !== 4'(i + 1)) begin
            tests_failed++;
            $display("FAIL b2b_tag%0d: got tag=%0d cmd=%0d expected %0d %0d", i, req_tag, req_cmd, i, i + 1);
         end
      end
      cmd_valid = 1'b0;
      tests_run++;
      if (inflight !== 3'd4 || cmd_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_full: got inflight=%0d ready=%b expected 4 0", inflight, cmd_ready);
      end
      out_resp = 2'd1; out_tag = 2'd2; out_data = 32'h22;
      cycle();
      out_resp = 2'd0;
      // Tag 2 is free but its response still holds a FIFO credit until popped.
      tests_run++;
      if (cmd_ready !== 1'b0 || inflight !== 3'd3 || rsp_tag !== 2'd2) begin
         tests_failed++;
         $display("FAIL b2b_credit: got ready=%b inflight=%0d rsp_tag=%0d expected 0 3 2", cmd_ready, inflight, rsp_tag);
      end
      cycle();
      tests_run++;
      if (cmd_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_ready_back: got %b expected 1", cmd_ready);
      end
      set_cmd(4'd9, 4'd0, 4'd0, 4'd0, 32'd0);
      cycle();
      cmd_valid = 1'b0;
      tests_run++;
      if (req_tag !== 2'd2 || req_cmd !== 4'd9) begin
         tests_failed++;
         $display("FAIL b2b_reuse: got tag=%0d cmd=%0d expected 2 9", req_tag, req_cmd);
      end
   endtask

   task automatic test_credit();
      do_reset();
      set_cmd(4'd3, 4'd0, 4'd0, 4'd0, 32'd0);
      cycle();
      set_cmd(4'd4, 4'd0, 4'd0, 4'd0, 32'd0);
      cycle();
      cmd_valid = 1'b0;
      out_resp = 2'd1; out_tag = 2'd0; out_data = 32'hA0;
      cycle();
      out_resp = 2'd2; out_tag = 2'd1; out_data = 32'hB1;
      cycle();
      out_resp = 2'd0;
      tests_run++;
      if (cmd_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL credit_two_queued: got ready=%b expected 1", cmd_ready);
      end
      set_cmd(4'd5, 4'd0, 4'd0, 4'd0, 32'd0);
      cycle();
      set_cmd(4'd6, 4'd0, 4'd0, 4'd0, 32'd0);
      cycle();
      cmd_valid = 1'b0;
      tests_run++;
      if (cmd_ready !== 1'b0 || inflight !== 3'd2 || req_tag !== 2'd1) begin
         tests_failed++;
         $display("FAIL credit_block: got ready=%b inflight=%0d tag=%0d expected 0 2 1", cmd_ready, inflight, req_tag);
      end
      tests_run++;
      if ({rsp_code, rsp_data, rsp_tag, rsp_op} !== {2'd1, 32'hA0, 2'd0, 4'd3}) begin
         tests_failed++;
         $display("FAIL credit_head0: got code=%0d data=%h tag=%0d op=%0d expected 1 a0 0 3", rsp_code, rsp_data, rsp_tag, rsp_op);
      end
      rsp_ready = 1'b1;
      cycle();
      rsp_ready = 1'b0;
      tests_run++;
      if (cmd_ready !== 1'b1 || {rsp_code, rsp_data, rsp_tag, rsp_op} !== {2'd2, 32'hB1, 2'd1, 4'd4}) begin
         tests_failed++;
         $display("FAIL credit_pop: got ready=%b code=%0d data=%h tag=%0d op=%0d expected 1 2 b1 1 4",
                  cmd_ready, rsp_code, rsp_data, rsp_tag, rsp_op);
      end
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      set_cmd(4'd5, 4'd0, 4'd0, 4'd0, 32'd0);
      cycle();
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 4 * TMO) begin
         cycle();
         n++;
      end
      // Timer reaches TMO after TMO clocks, then the push takes one more.
      tests_run++;
      if (n !== TMO + 1) begin
         tests_failed++;
         $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TMO + 1);
      end
      tests_run++;
      if ({rsp_code, rsp_data, rsp_tag, rsp_op, inflight} !== {2'd3, 32'd0, 2'd0, 4'd5, 3'd0}) begin
         tests_failed++;
         $display("FAIL timeout_entry: got code=%0d data=%h tag=%0d op=%0d inflight=%0d expected 3 0 0 5 0",
                  rsp_code, rsp_data, rsp_tag, rsp_op, inflight);
      end
      out_resp = 2'd1; out_tag = 2'd0; out_data = 32'h5;
      cycle();
      out_resp = 2'd0;
      tests_run++;
      if (err_unexp !== 1'b1) begin
         tests_failed++;
         $display("FAIL timeout_late_err: got %b expected 1", err_unexp);
      end
      cycle();
      tests_run++;
      if (err_unexp !== 1'b0) begin
         tests_failed++;
         $display("FAIL err_pulse_width: got %b expected 0", err_unexp);
      end
      rsp_ready = 1'b1;
      cycle();
      rsp_ready = 1'b0;
      tests_run++;
      if (rsp_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_late_nopush: got rsp_valid=%b expected 0", rsp_valid);
      end
   endtask

   task automatic test_collision();
      do_reset();
      set_cmd(4'd2, 4'd0, 4'd0, 4'd0, 32'd0);
      cycle();
      set_cmd(4'd3, 4'd0, 4'd0, 4'd0, 32'd0);
      cycle();
      cmd_valid = 1'b0;
      repeat (TMO - 1) cycle();
      // Tag 0 is expired in this cycle while tag 1 answers.
      out_resp = 2'd1; out_tag = 2'd1; out_data = 32'h77;
      cycle();
      out_resp = 2'd0;
      tests_run++;
      if ({rsp_valid, rsp_code, rsp_data, rsp_tag, rsp_op, inflight} !== {1'b1, 2'd1, 32'h77, 2'd1, 4'd3, 3'd1}) begin
         tests_failed++;
         $display("FAIL collide_first: got v=%b code=%0d data=%h tag=%0d op=%0d inflight=%0d expected 1 1 77 1 3 1",
                  rsp_valid, rsp_code, rsp_data, rsp_tag, rsp_op, inflight);
      end
      cycle();
      rsp_ready = 1'b1;
      cycle();
      tests_run++;
      if ({rsp_valid, rsp_code, rsp_data, rsp_tag, rsp_op, inflight} !== {1'b1, 2'd3, 32'd0, 2'd0, 4'd2, 3'd0}) begin
         tests_failed++;
         $display("FAIL collide_second: got v=%b code=%0d data=%h tag=%0d op=%0d inflight=%0d expected 1 3 0 0 2 0",
                  rsp_valid, rsp_code, rsp_data, rsp_tag, rsp_op, inflight);
      end
      cycle();
      rsp_ready = 1'b0;
      // Same tag: real response and expiry coincide; only the real one survives.
      set_cmd(4'd7, 4'd0, 4'd0, 4'd0, 32'd0);
      cycle();
      cmd_valid = 1'b0;
      repeat (TMO) cycle();
      out_resp = 2'd1; out_tag = 2'd0; out_data = 32'h99;
      cycle();
      out_resp = 2'd0;
      tests_run++;
      if ({rsp_code, rsp_data, rsp_tag, inflight, err_unexp} !== {2'd1, 32'h99, 2'd0, 3'd0, 1'b0}) begin
         tests_failed++;
         $display("FAIL same_tag_real: got code=%0d data=%h tag=%0d inflight=%0d err=%b expected 1 99 0 0 0",
                  rsp_code, rsp_data, rsp_tag, inflight, err_unexp);
      end
      rsp_ready = 1'b1;
      cycle();
      cycle();
      rsp_ready = 1'b0;
      tests_run++;
      if (rsp_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL same_tag_no_timeout: got rsp_valid=%b expected 0", rsp_valid);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_cmd(4'd1, 4'd0, 4'd0, 4'd0, 32'd0);
      cycle();
      set_cmd(4'd2, 4'd0, 4'd0, 4'd0, 32'd0);
      cycle();
      cmd_valid = 1'b0;
      out_resp = 2'd1; out_tag = 2'd0;
      cycle();
      out_tag = 2'd1;
      cycle();
      out_resp = 2'd0;
      set_cmd(4'd3, 4'd0, 4'd0, 4'd0, 32'd0);
      cycle();
      set_cmd(4'd4, 4'd0, 4'd0, 4'd0, 32'd0);
      cycle();
      cmd_valid = 1'b0;
      tests_run++;
      if (inflight !== 3'd2 || rsp_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL midreset_setup: got inflight=%0d rsp_valid=%b expected 2 1", inflight, rsp_valid);
      end
      reset = 1'b1;
      #1;
      tests_run++;
      if (all_out !== '0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: got %h expected 0", all_out);
      end
      cycle();
      reset = 1'b0;
      #1;
      tests_run++;
      if (cmd_ready !== 1'b1 || inflight !== 3'd0) begin
         tests_failed++;
         $display("FAIL midreset_release: got ready=%b inflight=%0d expected 1 0", cmd_ready, inflight);
      end
      out_resp = 2'd1; out_tag = 2'd1; out_data = 32'h1;
      cycle();
      out_resp = 2'd0;
      tests_run++;
      if (err_unexp !== 1'b1 || rsp_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_stale: got err=%b rsp_valid=%b expected 1 0", err_unexp, rsp_valid);
      end
   endtask

   task automatic test_random();
      logic [40:0] exp_rsp;
      logic [53:0] exp_req;
      int          bl[$];
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         exp_req = {m_req_cmd, m_req_d1, m_req_d2, m_req_r1, m_req_data, m_req_tag};
         exp_rsp = (m_q.size() > 0) ? {1'b1, m_q[0].code, m_q[0].data, m_q[0].tag, m_q[0].op} : '0;
         tests_run++;
         if (cmd_ready !== m_ready()) begin
            tests_failed++;
            $display("FAIL rand_ready c%0d: got %b expected %b", c, cmd_ready, m_ready());
         end
         tests_run++;
         if ({req_cmd, req_d1, req_d2, req_r1, req_data, req_tag} !== exp_req) begin
            tests_failed++;
            $display("FAIL rand_req c%0d: got %h expected %h", c,
                     {req_cmd, req_d1, req_d2, req_r1, req_data, req_tag}, exp_req);
         end
         tests_run++;
         if ({rsp_valid, rsp_code, rsp_data, rsp_tag, rsp_op} !== exp_rsp) begin
            tests_failed++;
            $display("FAIL rand_rsp c%0d: got %h expected %h", c,
                     {rsp_valid, rsp_code, rsp_data, rsp_tag, rsp_op}, exp_rsp);
         end
         tests_run++;
         if (inflight !== 3'(m_nbusy())) begin
            tests_failed++;
            $display("FAIL rand_inflight c%0d: got %0d expected %0d", c, inflight, m_nbusy());
         end
         tests_run++;
         if (err_unexp !== m_err) begin
            tests_failed++;
            $display("FAIL rand_err c%0d: got %b expected %b", c, err_unexp, m_err);
         end

         reset     = ($urandom_range(0, 399) == 0);
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_op    = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         cmd_d1    = 4'($urandom);
         cmd_d2    = 4'($urandom);
         cmd_r1    = 4'($urandom);
         cmd_data  = 32'($urandom);
         rsp_ready = ($urandom_range(0, 9) < 6);
         out_data  = 32'($urandom);
         bl.delete();
         for (int t = 0; t < 4; t++) if (m_busy[t]) bl.push_back(t);
         if ($urandom_range(0, 9) < 4) begin
            out_resp = 2'($urandom_range(1, 3));
            if (bl.size() > 0 && $urandom_range(0, 9) < 8)
               out_tag = 2'(bl[$urandom_range(0, bl.size() - 1)]);
            else
               out_tag = 2'($urandom_range(0, 3));
         end else begin
            out_resp = 2'd0;
         end
         cycle();
      end
      reset = 1'b0;
      cmd_valid = 1'b0;
      out_resp = 2'd0;
   endtask

   // Hard time limit so the bench can never hang.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      test_reset();
      test_single_issue();
      test_back_to_back();
      test_credit();
      test_timeout();
      test_collision();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
